// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the RV32IM instruction-fetch stage.
//   fetch_state_e : fetch FSM state (RUN, HALT, FAULT), 2-bit encoding
//   NOP_INSTR     : canonical NOP (addi x0, x0, 0) held in IF/ID after reset
//   PC_STEP       : sequential PC increment in bytes
//   is_aligned    : true when a byte address is on a 32-bit word boundary
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register between fetch and decode.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   load         : capture fetch_instr/fetch_pc and mark the slot valid
//   flush        : drop the held instruction (wins over load and consume)
//   consume      : decode took the held instruction; clears valid unless reloaded
//   fetch_instr  : instruction word from instruction memory
//   fetch_pc     : PC of fetch_instr
//   id_valid     : slot holds a valid instruction
//   id_instr     : held instruction (NOP after reset)
//   id_pc        : PC of the held instruction
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        consume,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
            id_pc    <= 32'h0;
        end else if (flush) begin
            // Contents are left as-is; only the valid flag matters after a flush.
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid <= 1'b1;
            id_instr <= fetch_instr;
            id_pc    <= fetch_pc;
        end else if (consume) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RV32IM core.
// Holds the PC, addresses a combinational instruction memory and hands the
// fetched word to decode through the IF/ID register with a valid/ready handshake.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   imem_addr       : byte address to instruction memory (low bits of pc)
//   imem_data       : instruction word returned combinationally for imem_addr
//   redirect_valid  : load redirect_pc and flush IF/ID this cycle
//   redirect_pc     : redirect target (misaligned target enters FAULT)
//   halt_req        : stop fetching after this cycle (RUN only)
//   id_ready        : decode accepts id_* this cycle
//   id_valid/id_instr/id_pc : registered instruction handed to decode
//   halted          : fetch is in HALT
//   fault           : fetch is in FAULT
//   fault_pc        : last misaligned redirect target
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  halt_req,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [31:0]           id_instr,
    output logic [31:0]           id_pc,
    output logic                  halted,
    output logic                  fault,
    output logic [31:0]           fault_pc
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  fault_pc_q;
    logic         slot_free;
    logic         do_fetch;
    logic         consume;

    // Upper PC bits simply alias onto the small memory.
    assign imem_addr = pc_q[ADDR_WIDTH-1:0];

    assign slot_free = !id_valid || id_ready;
    assign do_fetch  = (state_q == RUN) && !redirect_valid && !halt_req && slot_free;
    assign consume   = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'h0;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
            if (is_aligned(redirect_pc)) begin
                state_q <= RUN;
            end else begin
                state_q    <= FAULT;
                fault_pc_q <= redirect_pc;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (halt_req) begin
                        // pc already names the next instruction to fetch
                        state_q <= HALT;
                    end else if (slot_free) begin
                        pc_q <= pc_q + PC_STEP;
                    end
                end
                HALT:    ;
                FAULT:   ;
                default: state_q <= RUN;
            endcase
        end
    end

    assign halted   = (state_q == HALT);
    assign fault    = (state_q == FAULT);
    assign fault_pc = fault_pc_q;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (do_fetch),
        .flush       (redirect_valid),
        .consume     (consume),
        .fetch_instr (imem_data),
        .fetch_pc    (pc_q),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32IM core.
- Holds the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register and hands it to decode over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from downstream, and supports halting and misaligned-target faulting.

Parameters:
- ADDR_WIDTH, 8: byte-address width of the instruction memory; imem_addr = pc[ADDR_WIDTH-1:0].
- RESET_PC, 32'h0000_0000: PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory; combinational from the pc register.
- imem_data  input  32  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  one-cycle request to load a new PC and flush IF/ID.
- redirect_pc  input  32  redirect target.
- halt_req  input  1  stop fetching after the current cycle.
- id_ready  input  1  decode accepts id_* this cycle.
- id_valid  output  1  id_instr/id_pc hold a valid instruction.
- id_instr  output  32  fetched instruction.
- id_pc  output  32  PC of id_instr.
- halted  output  1  state == HALT.
- fault  output  1  state == FAULT (misaligned redirect target).
- fault_pc  output  32  offending redirect target.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, state=RUN.
  - id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0.
  - halted=0, fault=0, fault_pc=0.
  - rst overrides all other inputs, including mid-stall and mid-fault.
- imem_addr = pc[ADDR_WIDTH-1:0] in every state. Upper PC bits are ignored (address aliasing); no range check.
- Slot-free condition: load = !id_valid || id_ready.
- Priority per edge: rst > redirect_valid > halt_req > normal fetch.
- RUN, normal fetch:
  - If load: id_instr<=imem_data, id_pc<=pc, id_valid<=1, pc<=pc+4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
  - If !load (stall): pc and IF/ID hold unchanged.
  - Fetch latency: an instruction appears on id_* one cycle after its PC is on imem_addr.
  - Throughput is 1 instruction/cycle while id_ready=1.
- redirect_valid=1, any state:
  - id_valid<=0 (flush, regardless of id_ready); pc<=redirect_pc.
  - If redirect_pc[1:0]==0: state<=RUN, fault<=0.
  - Otherwise: state<=FAULT, fault_pc<=redirect_pc.
  - No instruction is latched in the redirect cycle; the first target instruction is on id_* two edges after redirect_valid is sampled.
- halt_req=1 in RUN (no redirect):
  - state<=HALT; no new instruction is latched that cycle.
  - pc holds the next-to-fetch address.
- HALT:
  - No fetch; pc frozen.
  - A pending id_valid stays until consumed, then clears on id_valid&&id_ready.
  - halted=1. Exit only by redirect or rst; halt_req is ignored.
- FAULT:
  - id_valid=0, fault=1; fault_pc stable.
  - Exit only by redirect (aligned → RUN; misaligned → stays in FAULT with fault_pc updated) or rst.
- Simultaneous redirect_valid and halt_req: redirect wins and the state goes to RUN/FAULT; halt_req is dropped.
- id_* outputs are registered; no combinational path from inputs to id_*, halted, fault or fault_pc. imem_addr depends only on the pc register.
- States: RUN, HALT, FAULT (2-bit encoding).

Decomposition:
- fetch_pkg holds:
  - the fetch_state_e enum {RUN, HALT, FAULT};
  - localparam NOP_INSTR = 32'h0000_0013;
  - localparam PC_STEP = 4.
- One natural sub-module: if_id_reg, containing id_valid/id_instr/id_pc with load/flush/consume controls.
- PC and FSM stay in fetch_stage.

Test Plan:
Bench pairs fetch_stage with an instruction memory image: word0=FEDCB0B7, word1=78900113, word2=001100B3, other words NOP.
1. Reset then id_ready=1: id_valid rises 1 edge after rst release. id_pc/id_instr are 0/FEDCB0B7, then 4/78900113, then 8/001100B3, then C/00000013.
2. Stall: id_ready=0 for 3 cycles while id_pc=4 → id_pc=4 and id_instr=78900113 held, pc=8 held; resume gives id_pc=8 next.
3. Redirect to 0x20 while id_valid=1 and id_ready=0 → id_valid=0 next cycle; the following edge gives id_pc=20, id_instr=00000013.
4. Redirect to 0x06 → fault=1, fault_pc=6, id_valid=0 held for 5 cycles; then redirect to 0x0 → fault=0, id_pc=0 two edges later.
5. halt_req at id_pc=4 with id_ready=0 → halted=1, id_valid stays 1; id_ready=1 clears id_valid, pc frozen at 8; same-cycle halt_req+redirect to 0x0 → RUN, halted=0.
6. Wrap: redirect to 0xFFFF_FFFC → id_pc=FFFF_FFFC, imem_addr=FC, then id_pc=0. Also assert rst while in FAULT → fault=0, pc=RESET_PC.
